// File: rtl/id_branch_controller.sv
// id_branch_controller
// ID-stage branch sequencing for the five-stage pipeline. It detects BEQ/BNE
// operand hazards against Execute producers and Memory-stage loads. It stalls
// Fetch/Decode and bubbles Execute until the operands are valid, drives the
// comparator forwarding selects, and turns the comparison into PC-source and
// IF/ID-flush decisions. A watchdog flags stall episodes that run too long.
// Optional feature: define BRANCH_STATS_EN to add taken/not-taken counters.
module id_branch_controller #(
   parameter int REG_ADDR_SZ = 5,
   parameter int MAX_STALL   = 3,
   parameter int CNT_SZ      = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_branch_D,
   input  logic                   i_branch_ne_D,
   input  logic [REG_ADDR_SZ-1:0] i_rs_D,
   input  logic [REG_ADDR_SZ-1:0] i_rt_D,
   input  logic                   i_reg_write_E,
   input  logic [REG_ADDR_SZ-1:0] i_write_reg_E,
   input  logic                   i_reg_write_M,
   input  logic                   i_mem_to_reg_M,
   input  logic [REG_ADDR_SZ-1:0] i_write_reg_M,
   input  logic                   i_comparison,
   output logic                   o_fwd_a_D,
   output logic                   o_fwd_b_D,
   output logic                   o_stall_F,
   output logic                   o_stall_D,
   output logic                   o_flush_E,
   output logic                   o_pc_src_D,
   output logic                   o_flush_D,
`ifdef BRANCH_STATS_EN
   output logic                   o_timeout,
   output logic [CNT_SZ-1:0]      o_taken_cnt,
   output logic [CNT_SZ-1:0]      o_not_taken_cnt
`else
   output logic                   o_timeout
`endif
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

   state_t     state;
   state_t     state_next;
   logic [3:0] scnt;
   logic [3:0] scnt_next;
   logic       timeout_q;

   logic       br;
   logic       match_e;
   logic       match_m;
   logic       hazard;
   logic       taken;
   logic       resolve;
   logic       timeout_hit;

   // Hazard detection, branch direction and the watchdog trigger condition.
   always_comb begin
      br          = i_branch_D | i_branch_ne_D;
      match_e     = i_reg_write_E & (i_write_reg_E != '0) &
                    ((i_write_reg_E == i_rs_D) | (i_write_reg_E == i_rt_D));
      match_m     = i_reg_write_M & i_mem_to_reg_M & (i_write_reg_M != '0) &
                    ((i_write_reg_M == i_rs_D) | (i_write_reg_M == i_rt_D));
      hazard      = br & (match_e | match_m);
      taken       = i_branch_D ? i_comparison : ~i_comparison;
      resolve     = br & ~hazard;
      timeout_hit = hazard & (state == STALL) & (scnt == MAX_CNT);
   end

   // Stall-episode FSM next state; scnt saturates once the watchdog limit is reached.
   always_comb begin
      state_next = state;
      scnt_next  = scnt;
      case (state)
         IDLE: begin
            if (hazard) begin
               state_next = STALL;
               scnt_next  = 4'd1;
            end
         end
         STALL: begin
            if (hazard) begin
               scnt_next = (scnt >= MAX_CNT) ? MAX_CNT : scnt + 4'd1;
            end else begin
               state_next = IDLE;
               scnt_next  = 4'd0;
            end
         end
         default: begin
            state_next = IDLE;
            scnt_next  = 4'd0;
         end
      endcase
   end

   // Output decode; every output is held low while reset is asserted.
   always_comb begin
      o_fwd_a_D  = 1'b0;
      o_fwd_b_D  = 1'b0;
      o_stall_F  = 1'b0;
      o_stall_D  = 1'b0;
      o_flush_E  = 1'b0;
      o_pc_src_D = 1'b0;
      o_flush_D  = 1'b0;
      o_timeout  = 1'b0;
      if (!i_reset) begin
         o_fwd_a_D  = i_reg_write_M & ~i_mem_to_reg_M & (i_write_reg_M != '0) &
                      (i_write_reg_M == i_rs_D);
         o_fwd_b_D  = i_reg_write_M & ~i_mem_to_reg_M & (i_write_reg_M != '0) &
                      (i_write_reg_M == i_rt_D);
         o_stall_F  = hazard;
         o_stall_D  = hazard;
         o_flush_E  = hazard;
         o_pc_src_D = resolve & taken;
         o_flush_D  = resolve & taken;
         o_timeout  = timeout_q | timeout_hit;
      end
   end

   // State, stall counter and sticky watchdog registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         scnt      <= 4'd0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         scnt      <= scnt_next;
         timeout_q <= timeout_q | timeout_hit;
      end
   end

`ifdef BRANCH_STATS_EN
   // Resolved-branch statistics; the counters wrap naturally at full scale.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_taken_cnt     <= '0;
         o_not_taken_cnt <= '0;
      end else if (resolve) begin
         if (taken) begin
            o_taken_cnt <= o_taken_cnt + 1'b1;
         end else begin
            o_not_taken_cnt <= o_not_taken_cnt + 1'b1;
         end
      end
   end
`else
   // CNT_SZ only sizes the optional counters; tie it off when they are absent.
   logic unused_cnt_sz;
   assign unused_cnt_sz = ^32'(CNT_SZ);
`endif

endmodule

// File: tb/tb_id_branch_controller.sv
// tb_id_branch_controller
// Directed bench for id_branch_controller. Inputs change 1 ns after a rising
// edge and outputs are compared on the falling edge. The outputs are packed as
// {fwd_a, fwd_b, stall_F, stall_D, flush_E, pc_src, flush_D, timeout}.
// Counter checks are included when BRANCH_STATS_EN is defined (CNT_SZ = 4).
module tb_id_branch_controller;

   logic       clk;
   logic       reset;
   logic       branch_d;
   logic       branch_ne_d;
   logic [4:0] rs_d;
   logic [4:0] rt_d;
   logic       reg_write_e;
   logic [4:0] write_reg_e;
   logic       reg_write_m;
   logic       mem_to_reg_m;
   logic [4:0] write_reg_m;
   logic       comparison;
   logic       fwd_a_d;
   logic       fwd_b_d;
   logic       stall_f;
   logic       stall_d;
   logic       flush_e;
   logic       pc_src_d;
   logic       flush_d;
   logic       timeout;
`ifdef BRANCH_STATS_EN
   logic [3:0] taken_cnt;
   logic [3:0] not_taken_cnt;
`endif

   int pass_count  = 0;
   int check_count = 0;

   id_branch_controller #(
      .REG_ADDR_SZ (5),
      .MAX_STALL   (3),
`ifdef BRANCH_STATS_EN
      .CNT_SZ      (4)
`else
      .CNT_SZ      (16)
`endif
   ) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_branch_D      (branch_d),
      .i_branch_ne_D   (branch_ne_d),
      .i_rs_D          (rs_d),
      .i_rt_D          (rt_d),
      .i_reg_write_E   (reg_write_e),
      .i_write_reg_E   (write_reg_e),
      .i_reg_write_M   (reg_write_m),
      .i_mem_to_reg_M  (mem_to_reg_m),
      .i_write_reg_M   (write_reg_m),
      .i_comparison    (comparison),
      .o_fwd_a_D       (fwd_a_d),
      .o_fwd_b_D       (fwd_b_d),
      .o_stall_F       (stall_f),
      .o_stall_D       (stall_d),
      .o_flush_E       (flush_e),
      .o_pc_src_D      (pc_src_d),
      .o_flush_D       (flush_d),
`ifdef BRANCH_STATS_EN
      .o_timeout       (timeout),
      .o_taken_cnt     (taken_cnt),
      .o_not_taken_cnt (not_taken_cnt)
`else
      .o_timeout       (timeout)
`endif
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's worth of inputs.
   task automatic applyStimulus(input logic rst, input logic beq, input logic bne,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic rw_e, input logic [4:0] wr_e,
                                input logic rw_m, input logic m2r, input logic [4:0] wr_m,
                                input logic cmp);
      reset        = rst;
      branch_d     = beq;
      branch_ne_d  = bne;
      rs_d         = rs;
      rt_d         = rt;
      reg_write_e  = rw_e;
      write_reg_e  = wr_e;
      reg_write_m  = rw_m;
      mem_to_reg_m = m2r;
      write_reg_m  = wr_m;
      comparison   = cmp;
   endtask

   // Single comparison point with pass/fail bookkeeping.
   task automatic checkValue(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Compare the packed outputs mid-cycle, then advance to just after the next edge.
   task automatic checkOutput(input string tag, input logic [7:0] expected);
      @(negedge clk);
      checkValue(tag, {8'h00, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e,
                       pc_src_d, flush_d, timeout}, {8'h00, expected});
      @(posedge clk);
      #1;
   endtask

   initial begin
      $display("[TB] starting id_branch_controller directed sequence");

      // Reset with a hazardous branch present: everything forced low.
      applyStimulus(1, 1,0, 5'd3,5'd4, 1,5'd3, 0,0,5'd0, 1);
      checkOutput("reset_forced_low", 8'h00);
      applyStimulus(0, 0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("idle_after_reset", 8'h00);

      // Hazard-free branches resolve immediately.
      applyStimulus(0, 1,0, 5'd3,5'd4, 0,5'd0, 0,0,5'd0, 1);
      checkOutput("beq_taken", 8'h06);
      applyStimulus(0, 1,0, 5'd3,5'd4, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("beq_not_taken", 8'h00);
      applyStimulus(0, 0,1, 5'd3,5'd4, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("bne_taken", 8'h06);

      // BNE on an ALU result in Execute: one stall, then forward from Memory.
      applyStimulus(0, 0,1, 5'd5,5'd6, 1,5'd5, 0,0,5'd0, 0);
      checkOutput("bne_alu_stall", 8'h38);
      applyStimulus(0, 0,1, 5'd5,5'd6, 0,5'd0, 1,0,5'd5, 0);
      checkOutput("bne_alu_fwd_resolve", 8'h86);

      // BEQ on a load: two stall cycles, resolve without forwarding.
      applyStimulus(0, 1,0, 5'd1,5'd7, 1,5'd7, 0,0,5'd0, 1);
      checkOutput("beq_load_in_e", 8'h38);
      applyStimulus(0, 1,0, 5'd1,5'd7, 0,5'd0, 1,1,5'd7, 1);
      checkOutput("beq_load_in_m", 8'h38);
      applyStimulus(0, 1,0, 5'd1,5'd7, 0,5'd0, 0,0,5'd0, 1);
      checkOutput("beq_load_resolve", 8'h06);

      // Execute and Memory hazards together; clearing only Execute keeps stalling.
      applyStimulus(0, 1,0, 5'd2,5'd9, 1,5'd2, 1,1,5'd9, 1);
      checkOutput("dual_hazard", 8'h38);
      applyStimulus(0, 1,0, 5'd2,5'd9, 0,5'd0, 1,1,5'd9, 1);
      checkOutput("m_hazard_remains", 8'h38);
      applyStimulus(0, 1,0, 5'd2,5'd9, 0,5'd0, 0,0,5'd0, 1);
      checkOutput("dual_resolve", 8'h06);

      // Register 0 never hazards or forwards.
      applyStimulus(0, 1,0, 5'd0,5'd4, 1,5'd0, 1,0,5'd0, 1);
      checkOutput("r0_no_hazard", 8'h06);

      // Forwarding selects are driven even without a branch.
      applyStimulus(0, 0,0, 5'd3,5'd4, 0,5'd0, 1,0,5'd4, 0);
      checkOutput("fwd_b_no_branch", 8'h40);

      // Reset in the middle of a stall aborts the episode.
      applyStimulus(0, 0,1, 5'd5,5'd6, 1,5'd6, 0,0,5'd0, 0);
      checkOutput("abort_stall_0", 8'h38);
      applyStimulus(0, 0,1, 5'd5,5'd6, 1,5'd6, 0,0,5'd0, 0);
      checkOutput("abort_stall_1", 8'h38);
      applyStimulus(1, 0,1, 5'd5,5'd6, 1,5'd6, 0,0,5'd0, 0);
      checkOutput("abort_reset_low", 8'h00);
      applyStimulus(0, 0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("abort_idle", 8'h00);

      // Watchdog: fires on the fourth stall cycle, saturates, stays sticky.
      applyStimulus(0, 1,0, 5'd8,5'd9, 1,5'd8, 0,0,5'd0, 1);
      checkOutput("wd_stall_0", 8'h38);
      checkOutput("wd_stall_1", 8'h38);
      checkOutput("wd_stall_2", 8'h38);
      checkOutput("wd_stall_3_fire", 8'h39);
      checkOutput("wd_stall_4_sat", 8'h39);
      applyStimulus(0, 1,0, 5'd8,5'd9, 0,5'd0, 0,0,5'd0, 1);
      checkOutput("wd_resolve", 8'h07);
      applyStimulus(0, 0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("wd_sticky", 8'h01);
      applyStimulus(1, 0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("wd_reset_low", 8'h00);
      applyStimulus(0, 0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("wd_cleared", 8'h00);

`ifdef BRANCH_STATS_EN
      // Counters start at zero after reset, taken count wraps after 16.
      checkValue("taken_cnt_reset", {12'h000, taken_cnt}, 16'd0);
      checkValue("not_taken_cnt_reset", {12'h000, not_taken_cnt}, 16'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 1,0, 5'd3,5'd4, 0,5'd0, 0,0,5'd0, 1);
         checkOutput("stats_taken", 8'h06);
         if (i == 14) checkValue("taken_cnt_15", {12'h000, taken_cnt}, 16'd15);
      end
      checkValue("taken_cnt_wrap", {12'h000, taken_cnt}, 16'd0);
      applyStimulus(0, 1,0, 5'd3,5'd4, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("stats_not_taken", 8'h00);
      checkValue("not_taken_cnt_1", {12'h000, not_taken_cnt}, 16'd1);
      checkValue("taken_cnt_hold", {12'h000, taken_cnt}, 16'd0);
      applyStimulus(0, 0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0);
      checkOutput("stats_idle", 8'h00);
      checkValue("not_taken_cnt_hold", {12'h000, not_taken_cnt}, 16'd1);
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
